// File: rtl/request_unit.sv
// -----------------------------------------------------------------------------
// request_unit
//
// Purpose:
//   Sequences memory requests for a multicycle datapath. It watches decoded
//   control (dREN/dWEN/halt) and the memory hit returns (ihit/dhit), then
//   drives the registered instruction/data requests, a one-cycle PC-advance
//   pulse, a sticky halt flag and a retired-instruction counter.
//
// Ports:
//   CLK          in   system clock, rising edge
//   RST          in   synchronous active-high reset
//   iREN         in   fetch request from decode (fetch always happens in FETCH)
//   dREN         in   decoded instruction is a load
//   dWEN         in   decoded instruction is a store
//   halt         in   decoded instruction is HALT or an overflow trap
//   ihit         in   instruction memory returned data this cycle
//   dhit         in   data memory completed its access this cycle
//   imemREN      out  instruction read request (registered)
//   dmemREN      out  data read request (registered)
//   dmemWEN      out  data write request (registered)
//   pc_en        out  one-cycle PC advance / commit pulse (registered)
//   halt_out     out  sticky halted flag
//   instr_count  out  instructions retired since reset, wraps silently
//   err_timeout  out  watchdog fired (tied to 0 unless REQ_TIMEOUT_EN)
//
// Optional build macro:
//   REQ_TIMEOUT_EN - adds a wait-cycle watchdog that forces HALTED with
//                    err_timeout set when no hit arrives for TIMEOUT_CYCLES.
// -----------------------------------------------------------------------------
module request_unit #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             iREN,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic             halt,
    input  logic             ihit,
    input  logic             dhit,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             halt_out,
    output logic [CNT_W-1:0] instr_count,
    output logic             err_timeout
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             imem_ren_q, imem_ren_d;
    logic             dmem_ren_q, dmem_ren_d;
    logic             dmem_wen_q, dmem_wen_d;
    logic             pc_en_q, pc_en_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             hit_accepted;

    // Fetch is unconditional in FETCH, so iREN carries no information here.
    logic unused_inputs;
    assign unused_inputs = iREN ^ (TIMEOUT_CYCLES == 0);

`ifdef REQ_TIMEOUT_EN
    localparam int               WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic              timeout_fire;
`endif

    // A hit only counts when the current state is waiting for it. An ihit
    // while pc_en is high belongs to the previous PC and is discarded.
    always_comb begin
        hit_accepted = 1'b0;
        case (state_q)
            FETCH:   hit_accepted = ihit && !pc_en_q;
            DATA:    hit_accepted = dhit;
            default: hit_accepted = 1'b0;
        endcase
    end

`ifdef REQ_TIMEOUT_EN
    // The hit wins when it lands in the same cycle the limit is reached.
    assign timeout_fire = ((state_q == FETCH) || (state_q == DATA)) &&
                          !hit_accepted && (wait_q == WAIT_LIMIT);
`endif

    always_comb begin
        state_d    = state_q;
        imem_ren_d = imem_ren_q;
        dmem_ren_d = dmem_ren_q;
        dmem_wen_d = dmem_wen_q;
        pc_en_d    = 1'b0;
        halt_d     = halt_q;
        count_d    = count_q;

        case (state_q)
            FETCH: begin
                if (hit_accepted) begin
                    // halt beats memory ops; a store beats a load
                    if (halt) begin
                        state_d    = HALTED;
                        imem_ren_d = 1'b0;
                        halt_d     = 1'b1;
                    end else if (dWEN) begin
                        state_d    = DATA;
                        imem_ren_d = 1'b0;
                        dmem_wen_d = 1'b1;
                    end else if (dREN) begin
                        state_d    = DATA;
                        imem_ren_d = 1'b0;
                        dmem_ren_d = 1'b1;
                    end else begin
                        imem_ren_d = 1'b1;
                        pc_en_d    = 1'b1;
                        count_d    = count_q + CNT_ONE;
                    end
                end
            end
            DATA: begin
                if (hit_accepted) begin
                    state_d    = FETCH;
                    imem_ren_d = 1'b1;
                    dmem_ren_d = 1'b0;
                    dmem_wen_d = 1'b0;
                    pc_en_d    = 1'b1;
                    count_d    = count_q + CNT_ONE;
                end
            end
            default: begin
                state_d    = HALTED;
                imem_ren_d = 1'b0;
                dmem_ren_d = 1'b0;
                dmem_wen_d = 1'b0;
                halt_d     = 1'b1;
            end
        endcase

`ifdef REQ_TIMEOUT_EN
        err_d = err_q;
        if (timeout_fire) begin
            state_d    = HALTED;
            imem_ren_d = 1'b0;
            dmem_ren_d = 1'b0;
            dmem_wen_d = 1'b0;
            pc_en_d    = 1'b0;
            halt_d     = 1'b1;
            err_d      = 1'b1;
        end

        // The wait counter measures cycles since the last progress event.
        if ((state_d != state_q) || hit_accepted) begin
            wait_d = '0;
        end else if ((state_q == FETCH) || (state_q == DATA)) begin
            wait_d = wait_q + WAIT_ONE;
        end else begin
            wait_d = wait_q;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= FETCH;
            imem_ren_q <= 1'b1;
            dmem_ren_q <= 1'b0;
            dmem_wen_q <= 1'b0;
            pc_en_q    <= 1'b0;
            halt_q     <= 1'b0;
            count_q    <= '0;
`ifdef REQ_TIMEOUT_EN
            wait_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            imem_ren_q <= imem_ren_d;
            dmem_ren_q <= dmem_ren_d;
            dmem_wen_q <= dmem_wen_d;
            pc_en_q    <= pc_en_d;
            halt_q     <= halt_d;
            count_q    <= count_d;
`ifdef REQ_TIMEOUT_EN
            wait_q     <= wait_d;
            err_q      <= err_d;
`endif
        end
    end

    assign imemREN     = imem_ren_q;
    assign dmemREN     = dmem_ren_q;
    assign dmemWEN     = dmem_wen_q;
    assign pc_en       = pc_en_q;
    assign halt_out    = halt_q;
    assign instr_count = count_q;

`ifdef REQ_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_request_unit.sv
// -----------------------------------------------------------------------------
// tb_request_unit
//
// Directed testbench for request_unit. A transaction-level model tracks the
// outstanding memory operation, the halted flag and the retired count, and a
// compare process checks every DUT output against it on each falling edge.
// A few literal expectations pin the model at known points in the sequence.
// -----------------------------------------------------------------------------
module tb_request_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN, halt, ihit, dhit;
    logic        imemREN, dmemREN, dmemWEN, pc_en, halt_out, err_timeout;
    logic [31:0] instr_count;

    int vectorCount = 0;
    int missCount   = 0;

    // Model state: pendingOp is 0 (none), 1 (load waiting) or 2 (store waiting)
    int          pendingOp   = 0;
    bit          modelHalted = 1'b0;
    bit          modelPulse  = 1'b0;
    bit          modelValid  = 1'b0;
    logic [31:0] modelCount  = 32'd0;
    logic        prevPc      = 1'b0;

    request_unit #(.CNT_W(32), .TIMEOUT_CYCLES(1024)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .iREN        (iREN),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .halt        (halt),
        .ihit        (ihit),
        .dhit        (dhit),
        .imemREN     (imemREN),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .pc_en       (pc_en),
        .halt_out    (halt_out),
        .instr_count (instr_count),
        .err_timeout (err_timeout)
    );

    // Free-running clock, 10 time-unit period.
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Each call occupies one clock: inputs change on the falling edge so the
    // next rising edge sees them stable.
    task automatic applyStimulus(input logic rst, input logic dr, input logic dw,
                                 input logic h, input logic ih, input logic dh);
        @(negedge CLK);
        RST  = rst;
        dREN = dr;
        dWEN = dw;
        halt = h;
        ihit = ih;
        dhit = dh;
    endtask

    // Transaction model: an instruction is either retired directly on its
    // fetch, parked as a pending load/store until dhit, or halts the machine.
    // A fetch hit right after a retire pulse is stale and dropped.
    always @(posedge CLK) begin
        if (RST) begin
            pendingOp   <= 0;
            modelHalted <= 1'b0;
            modelPulse  <= 1'b0;
            modelCount  <= 32'd0;
            modelValid  <= 1'b1;
        end else if (modelHalted) begin
            modelPulse <= 1'b0;
        end else if (pendingOp != 0) begin
            modelPulse <= dhit;
            if (dhit) begin
                pendingOp  <= 0;
                modelCount <= modelCount + 32'd1;
            end
        end else if (ihit && !modelPulse) begin
            if (halt)      modelHalted <= 1'b1;
            else if (dWEN) pendingOp   <= 2;
            else if (dREN) pendingOp   <= 1;
            modelPulse <= !halt && !dWEN && !dREN;
            if (!halt && !dWEN && !dREN) modelCount <= modelCount + 32'd1;
        end else begin
            modelPulse <= 1'b0;
        end
    end

    // Compare every output against the model on each falling edge once the
    // first reset has been seen, plus the two structural invariants.
    always @(negedge CLK) begin
        if (modelValid) begin
            checkOutput("imemREN", {31'd0, imemREN}, {31'd0, (!modelHalted && pendingOp == 0)});
            checkOutput("dmemREN", {31'd0, dmemREN}, {31'd0, (pendingOp == 1)});
            checkOutput("dmemWEN", {31'd0, dmemWEN}, {31'd0, (pendingOp == 2)});
            checkOutput("pc_en", {31'd0, pc_en}, {31'd0, modelPulse});
            checkOutput("halt_out", {31'd0, halt_out}, {31'd0, modelHalted});
            checkOutput("instr_count", instr_count, modelCount);
            checkOutput("err_timeout", {31'd0, err_timeout}, 32'd0);
            checkOutput("pcEnBackToBack", {31'd0, (prevPc & pc_en)}, 32'd0);
            checkOutput("dmemBothHigh", {31'd0, (dmemREN & dmemWEN)}, 32'd0);
            prevPc <= pc_en;
        end
    end

    // Directed sequence with literal checkpoints.
    initial begin
        RST = 1'b1; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0;
        halt = 1'b0; ihit = 1'b0; dhit = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("resetImem", {31'd0, imemREN}, 32'd1);
        checkOutput("resetCount", instr_count, 32'd0);

        // ALU stream, first one with dhit also high (must be ignored)
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 1, (i == 0));
            applyStimulus(0, 0, 0, 0, 0, 0);
        end
        checkOutput("aluCount", instr_count, 32'd5);
        checkOutput("aluPcEn", {31'd0, pc_en}, 32'd1);

        // Load with dhit three cycles after the request appears
        applyStimulus(0, 1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("loadReq", {31'd0, dmemREN}, 32'd1);
        checkOutput("loadImemOff", {31'd0, imemREN}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("loadPcEn", {31'd0, pc_en}, 32'd1);
        checkOutput("loadCount", instr_count, 32'd6);

        // Store with load also asserted: store wins
        applyStimulus(0, 1, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("storeWen", {31'd0, dmemWEN}, 32'd1);
        checkOutput("storeRen", {31'd0, dmemREN}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("storePcEn", {31'd0, pc_en}, 32'd1);
        checkOutput("storeCount", instr_count, 32'd7);

        // ihit held high: only every other hit is accepted
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("staleCount", instr_count, 32'd10);

        // Reset in the middle of a load
        applyStimulus(0, 1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("midResetRen", {31'd0, dmemREN}, 32'd0);
        checkOutput("midResetImem", {31'd0, imemREN}, 32'd1);
        checkOutput("midResetCount", instr_count, 32'd0);

        // Halt beats load; hits afterwards change nothing
        applyStimulus(0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 1, 0, (i % 2 == 0), (i % 2 == 1));
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("haltFlag", {31'd0, halt_out}, 32'd1);
        checkOutput("haltImem", {31'd0, imemREN}, 32'd0);
        checkOutput("haltRen", {31'd0, dmemREN}, 32'd0);
        checkOutput("haltCount", instr_count, 32'd0);

        applyStimulus(0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
